// File: rtl/piso_sched_pkg.sv
// ============================================================================
//  Module   : piso_sched_pkg
//  Purpose  : Shared state encoding and default sizing for the PISO TX scheduler
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package piso_sched_pkg;

    localparam int C_DEF_WIDTH   = 16;
    localparam int C_DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage : piso_sched_pkg

`default_nettype wire

// File: rtl/piso_shift.sv
// ============================================================================
//  Module   : piso_shift
//  Purpose  : WIDTH-bit right shift register, parallel load, LSB as serial out
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_shift
    import piso_sched_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_sout
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift; zeros enter from the top so an idle register drains to 0.
    always_comb begin
        shreg_d = shreg_q;
        if (i_load) begin
            shreg_d = i_din;
        end else if (i_shift) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign o_sout = shreg_q[0];

endmodule : piso_shift

`default_nettype wire

// File: rtl/piso_tx_sched.sv
// ============================================================================
//  Module   : piso_tx_sched
//  Purpose  : Round-robin grant of parallel words onto one LSB-first serial line
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_tx_sched
    import piso_sched_pkg::*;
#(
    parameter int WIDTH      = C_DEF_WIDTH,
    parameter int NUM_REQ    = C_DEF_NUM_REQ,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       serial_out,
    output logic                       serial_valid,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy
);

    localparam int C_IDW = $clog2(NUM_REQ);
    localparam int C_CW  = $clog2(WIDTH);
    localparam int C_GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [C_CW-1:0] C_LAST_BIT = C_CW'(WIDTH - 1);
    localparam logic [C_GW-1:0] C_GAP_LAST = C_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [C_CW-1:0]  cnt_q,   cnt_d;
    logic [C_GW-1:0]  gap_q,   gap_d;
    logic [C_IDW-1:0] ptr_q,   ptr_d;
    logic [C_IDW-1:0] id_q,    id_d;

    logic             w_grant;
    logic [C_IDW-1:0] w_win;
    logic [WIDTH-1:0] w_word;
    logic             w_sout;

    // First valid index after p, wrapping; later (larger) offsets are overwritten by nearer ones.
    function automatic logic [C_IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [C_IDW-1:0]   p);
        logic [C_IDW-1:0] w;
        logic [C_IDW-1:0] idx;
        w = p;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = C_IDW'((int'(p) + off) % NUM_REQ);
            if (v[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    assign w_win     = rr_pick(req_valid, ptr_q);
    assign w_grant   = (state_q == IDLE) && enable && (|req_valid) && !rst;
    assign w_word    = req_data[int'(w_win)*WIDTH +: WIDTH];
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (w_grant) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ptr_d   = w_win;
                    id_d    = w_win;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_BIT) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to the last index so requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= C_IDW'(NUM_REQ - 1);
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_grant),
        .i_shift (state_q == SHIFT),
        .i_din   (w_word),
        .o_sout  (w_sout)
    );

    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = serial_valid & w_sout;
    assign frame_start  = serial_valid && (cnt_q == '0);
    assign frame_end    = serial_valid && (cnt_q == C_LAST_BIT);
    assign busy         = (state_q != IDLE);
    assign active_id    = id_q;

endmodule : piso_tx_sched

`default_nettype wire

// File: tb/tb_piso_tx_sched.sv
// ============================================================================
//  Module   : tb_piso_tx_sched
//  Purpose  : Two scheduler instances (no gap / 3-cycle gap) against a timing model
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_piso_tx_sched;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int GAP1 = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en   [2];
    logic [N-1:0]     vld  [2];
    logic [N*W-1:0]   dat  [2];
    logic [N-1:0]     rdy  [2];
    logic             so   [2];
    logic             sv   [2];
    logic             fs   [2];
    logic             fe   [2];
    logic [1:0]       aid  [2];
    logic             bsy  [2];
    wire  [10:0]      obs  [2];

    int n_cmp, n_bad, tcyc, mode;
    int g0_id[$], g0_t[$], g1_id[$], g1_t[$];

    always #5 clk = ~clk;

    piso_tx_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .req_valid(vld[0]), .req_data(dat[0]),
        .req_ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]),
        .frame_start(fs[0]), .frame_end(fe[0]), .active_id(aid[0]), .busy(bsy[0]));

    piso_tx_sched #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(GAP1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .req_valid(vld[1]), .req_data(dat[1]),
        .req_ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]),
        .frame_start(fs[1]), .frame_end(fe[1]), .active_id(aid[1]), .busy(bsy[1]));

    assign obs[0] = {rdy[0], so[0], sv[0], fs[0], fe[0], aid[0], bsy[0]};
    assign obs[1] = {rdy[1], so[1], sv[1], fs[1], fe[1], aid[1], bsy[1]};

    // Reference model: only the last grant (edge number, word, id) and the RR pointer are kept;
    // everything else follows from elapsed edges since that grant.
    int           m_edge  [2];
    int           m_gedge [2];
    int           m_gid   [2];
    int           m_ptr   [2];
    logic [W-1:0] m_word  [2];

    function automatic int gap_of(int d);
        return (d == 1) ? GAP1 : 0;
    endfunction

    function automatic logic model_busy(int d);
        return (m_gedge[d] >= 0) && ((m_edge[d] - m_gedge[d]) < W + gap_of(d));
    endfunction

    function automatic int model_pick(int d);
        int r;
        r = -1;
        if (!rst && en[d] && !model_busy(d)) begin
            for (int off = 1; off <= N; off++) begin
                int i;
                i = (m_ptr[d] + off) % N;
                if (r < 0 && vld[d][i]) r = i;
            end
        end
        return r;
    endfunction

    function automatic logic [10:0] model_out(int d);
        int         p, diff;
        logic       sh, bit_v;
        logic [3:0] rr;
        p     = model_pick(d);
        rr    = (p >= 0) ? 4'(1 << p) : 4'b0;
        diff  = m_edge[d] - m_gedge[d];
        sh    = (m_gedge[d] >= 0) && (diff < W);
        bit_v = sh ? m_word[d][diff % W] : 1'b0;
        return {rr, bit_v, sh, sh && (diff == 0), sh && (diff == W-1), 2'(m_gid[d]), model_busy(d)};
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_edge[d]  <= 0;
                m_gedge[d] <= -1;
                m_gid[d]   <= 0;
                m_ptr[d]   <= N - 1;
                m_word[d]  <= '0;
            end else begin
                if (model_pick(d) >= 0) begin
                    m_gedge[d] <= m_edge[d] + 1;
                    m_gid[d]   <= model_pick(d);
                    m_ptr[d]   <= model_pick(d);
                    m_word[d]  <= dat[d][model_pick(d)*W +: W];
                end
                m_edge[d] <= m_edge[d] + 1;
            end
        end
    end

    function automatic int gid(int d, int k);
        return (d == 0) ? g0_id[k] : g1_id[k];
    endfunction

    function automatic int gt(int d, int k);
        return (d == 0) ? g0_t[k] : g1_t[k];
    endfunction

    function automatic int gsize(int d);
        return (d == 0) ? g0_id.size() : g1_id.size();
    endfunction

    // Log grants seen this cycle, cross the edge, then let each requester react.
    task automatic advance();
        logic [N-1:0] r [2];
        for (int d = 0; d < 2; d++) begin
            r[d] = rdy[d];
            for (int i = 0; i < N; i++) begin
                if (r[d][i]) begin
                    if (d == 0) begin g0_id.push_back(i); g0_t.push_back(tcyc); end
                    else        begin g1_id.push_back(i); g1_t.push_back(tcyc); end
                end
            end
        end
        @(posedge clk);
        #1;
        tcyc++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (r[d][i]) begin
                    if (mode == 0) vld[d][i] = 1'b0;
                    else begin
                        dat[d][i*W +: W] = W'($urandom);
                        if (mode == 2) vld[d][i] = 1'($urandom_range(0, 1));
                    end
                end else if (mode == 2) begin
                    if (!vld[d][i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            vld[d][i] = 1'b1;
                            dat[d][i*W +: W] = W'($urandom);
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        vld[d][i] = 1'b0;
                    end
                end
            end
            if (mode == 2 && $urandom_range(0, 15) == 0) en[d] = !en[d];
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        mode = 0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; vld[d] = '0; dat[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        g0_id.delete(); g0_t.delete(); g1_id.delete(); g1_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = 4'hF; dat[d] = {$urandom, $urandom};
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== 11'b0) begin
                    n_bad++;
                    $display("FAIL reset_outputs dut%0d: got %b want %b", d, obs[d], 11'b0);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [W-1:0] got [2];
        int nb[2], nrdy[2], nbusy[2], fs_at[2], fe_at[2];
        do_reset();
        for (int d = 0; d < 2; d++) begin
            vld[d] = 4'b0001; dat[d][W-1:0] = 16'hA5C3; en[d] = 1'b1;
            got[d] = '0; nb[d] = 0; nrdy[d] = 0; nbusy[d] = 0; fs_at[d] = -1; fe_at[d] = -1;
        end
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL single dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
                if (rdy[d] != 0) nrdy[d]++;
                if (bsy[d]) nbusy[d]++;
                if (fs[d]) fs_at[d] = nb[d];
                if (fe[d]) fe_at[d] = nb[d];
                if (sv[d]) begin
                    if (nb[d] < W) got[d][nb[d]] = so[d];
                    nb[d]++;
                end
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (got[d] !== 16'hA5C3 || nb[d] != W) begin
                n_bad++;
                $display("FAIL single_bits dut%0d: got %h (%0d bits) want a5c3 (16 bits)", d, got[d], nb[d]);
            end
            n_cmp++;
            if (nrdy[d] != 1 || fs_at[d] != 0 || fe_at[d] != W-1) begin
                n_bad++;
                $display("FAIL single_markers dut%0d: ready=%0d fs@%0d fe@%0d want 1/0/15", d, nrdy[d], fs_at[d], fe_at[d]);
            end
            n_cmp++;
            if (nbusy[d] != W + gap_of(d)) begin
                n_bad++;
                $display("FAIL single_busy dut%0d: got %0d want %0d", d, nbusy[d], W + gap_of(d));
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = 4'hF; dat[d] = {$urandom, $urandom};
        end
        for (int c = 0; c < 85; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL rr dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (gsize(d) < 5) begin
                n_bad++;
                $display("FAIL rr_count dut%0d: got %0d grants want >=5", d, gsize(d));
            end else begin
                for (int k = 0; k < 5; k++) begin
                    n_cmp++;
                    if (gid(d, k) != k % N || (k > 0 && gt(d, k) - gt(d, k-1) != W + 1 + gap_of(d))) begin
                        n_bad++;
                        $display("FAIL rr_order dut%0d #%0d: id %0d want %0d", d, k, gid(d, k), k % N);
                    end
                end
            end
        end
        mode = 0;
    endtask

    task automatic test_gap();
        int ngap[2];
        do_reset();
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = 4'b0110; dat[d] = {$urandom, $urandom}; ngap[d] = 0;
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL gap dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
                if (bsy[d] && !sv[d]) ngap[d]++;
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (gsize(d) != 2 || gid(d, 0) != 1 || gid(d, 1) != 2 || gt(d, 1) - gt(d, 0) != W + 1 + gap_of(d)) begin
                n_bad++;
                $display("FAIL gap_grants dut%0d: %0d grants, spacing %0d want 2 / %0d", d, gsize(d),
                         (gsize(d) > 1) ? gt(d, 1) - gt(d, 0) : -1, W + 1 + gap_of(d));
            end
            n_cmp++;
            if (ngap[d] != 2 * gap_of(d)) begin
                n_bad++;
                $display("FAIL gap_cycles dut%0d: got %0d want %0d", d, ngap[d], 2 * gap_of(d));
            end
        end
    endtask

    task automatic test_enable();
        int nb[2], quiet_bad[2], t_en;
        do_reset();
        mode = 1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; vld[d] = 4'hF; dat[d] = {$urandom, $urandom}; nb[d] = 0; quiet_bad[d] = 0;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL enable_low dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
                if (rdy[d] != 0 || sv[d]) quiet_bad[d]++;
            end
            advance();
        end
        t_en = tcyc;
        for (int d = 0; d < 2; d++) en[d] = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL enable_frame dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
                if (sv[d]) begin
                    if (nb[d] == 5) en[d] = 1'b0;
                    nb[d]++;
                end
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (quiet_bad[d] != 0) begin
                n_bad++;
                $display("FAIL enable_quiet dut%0d: %0d active cycles want 0", d, quiet_bad[d]);
            end
            n_cmp++;
            if (gsize(d) != 1 || gid(d, 0) != 0 || gt(d, 0) != t_en || nb[d] != W) begin
                n_bad++;
                $display("FAIL enable_grant dut%0d: %0d grants, %0d bits want 1 grant of id 0 at t=%0d, 16 bits",
                         d, gsize(d), nb[d], t_en);
            end
        end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        int nb, nfe;
        do_reset();
        nb = 0; nfe = 0;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = 4'b0100; dat[d] = {$urandom, $urandom};
        end
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL rstmid_frame dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
                if (fe[d]) nfe++;
            end
            if (sv[0]) nb++;
            if (nb == 8) break;
            advance();
        end
        #2 rst = 1'b1;
        for (int d = 0; d < 2; d++) vld[d] = 4'b1100;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs[d] !== 11'b0 || nfe != 0) begin
                n_bad++;
                $display("FAIL rstmid_abort dut%0d: got %b fe=%0d want all zero, fe=0", d, obs[d], nfe);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        g0_id.delete(); g0_t.delete(); g1_id.delete(); g1_t.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL rstmid_after dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (gsize(d) != 2 || gid(d, 0) != 2 || gid(d, 1) != 3) begin
                n_bad++;
                $display("FAIL rstmid_order dut%0d: %0d grants, first id %0d want 2 then 3", d, gsize(d),
                         (gsize(d) > 0) ? gid(d, 0) : -1);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = 4'b0001; dat[d] = {$urandom, $urandom};
        end
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL withdraw dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
            end
            advance();
            if (c == 0) for (int d = 0; d < 2; d++) vld[d] = vld[d] | 4'b1010;
            if (c == 5) for (int d = 0; d < 2; d++) vld[d][1] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (gsize(d) != 2 || gid(d, 0) != 0 || gid(d, 1) != 3) begin
                n_bad++;
                $display("FAIL withdraw_order dut%0d: %0d grants, second id %0d want 0 then 3", d, gsize(d),
                         (gsize(d) > 1) ? gid(d, 1) : -1);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        mode = 2;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; vld[d] = N'($urandom); dat[d] = {$urandom, $urandom};
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_out(d)) begin
                    n_bad++;
                    $display("FAIL random dut%0d t=%0d: got %b want %b", d, tcyc, obs[d], model_out(d));
                end
            end
            advance();
        end
        mode = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; tcyc = 0; mode = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; vld[d] = '0; dat[d] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_gap();
        test_enable();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_piso_tx_sched

`default_nettype wire

// File: doc/piso_tx_sched.md
# piso_tx_sched

Round-robin transmit scheduler for the 16-bit PISO serializer path. Accepts parallel words from up to NUM_REQ requesters over valid/ready handshakes, grants one word at a time, loads it into an internal shift register, and shifts it out LSB-first with frame markers. It sits between the word producers and the single serial output line.

## Interface
- WIDTH, 16, word and shift-register width (≥2)
- NUM_REQ, 4, number of requesters (≥2)
- GAP_CYCLES, 0, extra idle cycles inserted after each frame (≥0)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  gates new grants only; an in-flight frame always completes
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot acceptance pulse, one cycle
- serial_out  out  1  current bit, LSB first
- serial_valid  out  1  serial_out carries a frame bit
- frame_start  out  1  high with bit 0 of a frame
- frame_end  out  1  high with bit WIDTH-1 of a frame
- active_id  out  $clog2(NUM_REQ)  requester index of the current frame
- busy  out  1  high in SHIFT or GAP

## Operation
- Clock `clk`; reset `rst` is asynchronous and active-high. Assertion immediately clears all state: state=IDLE, shift register=0, bit counter=0, gap counter=0, RR pointer=NUM_REQ-1. All outputs read 0 during and after reset until the first grant.
- States: IDLE, SHIFT, GAP.
- IDLE → SHIFT: enable=1 and any req_valid. Winner is the first valid index searched from (ptr+1) mod NUM_REQ upward with wrap. At that edge: req_ready[winner]=1 for that cycle (combinational from state and inputs), shift register ← winner's word, active_id ← winner, ptr ← winner, bit counter ← 0.
- SHIFT: serial_out=shreg[0] and serial_valid=1. Each edge shifts right with 0 fill and increments the counter. frame_start when counter==0; frame_end when counter==WIDTH-1.
- SHIFT → GAP after the last bit if GAP_CYCLES>0. Otherwise SHIFT → IDLE.
- GAP: hold for GAP_CYCLES cycles with serial_valid=0, then go to IDLE.
- Arbitration occurs only in IDLE, so a requester cannot be granted twice while another is waiting.
- Requesters hold valid and data stable until ready. Dropping valid before a grant withdraws the request without error.
- enable=0 in IDLE: no grant and req_ready=0. Deasserting enable mid-frame has no effect on that frame.
- active_id holds its value after the frame ends, until the next grant.

## Timing
- A grant at edge k puts bit 0 on serial_out after k. The last bit is driven in cycle k+WIDTH. The earliest next grant is at edge k+WIDTH+GAP_CYCLES+1.
- Frame period under continuous requests: WIDTH+1+GAP_CYCLES cycles (16+1+0=17 by default).
- serial_out, serial_valid, frame_start, frame_end and busy are registered or decoded from registered state only, with no input-to-output combinational path. req_ready is the only combinational output.
- Reset asserted mid-frame aborts the frame: serial_valid drops with no frame_end. After release, the first grant goes to requester 0 if it is valid.

## Structure
- Package piso_sched_pkg holds the state enum (IDLE, SHIFT, GAP) and the default WIDTH and NUM_REQ constants.
- One sub-module: piso_shift, containing the WIDTH-bit shift register with load and shift enables, async active-high clear, and output shreg[0].
- The RR arbiter is a function in piso_tx_sched, not a separate module.

## Test plan
- Reset then single request: req_valid=4'b0001, data 16'hA5C3 → req_ready[0] pulses once; serial_out is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles; frame_start on the first bit, frame_end on the last, busy for 16 cycles.
- All four requesters valid and held: grants go in order 0,1,2,3,0 at 17-cycle spacing; active_id follows the same order; each frame serializes the correct word.
- GAP_CYCLES=3, requesters 1 and 2 valid: a 3-cycle serial_valid=0 gap plus 1 IDLE cycle separate the frames; the second grant lands 20 cycles after the first.
- enable=0 with req_valid=4'b1111 for 10 cycles → no req_ready and no serial_valid. Raise enable → requester 0 is granted next cycle. Drop enable at bit 5 → the frame completes all 16 bits and no new grant follows.
- rst asserted at bit 7 of a frame from requester 2 → all outputs 0 immediately with no frame_end. After release, with requesters 2 and 3 valid, requester 2 is granted first because the pointer was reset.
- Requester 1 drops valid before being reached while requesters 1 and 3 are pending → requester 3 is granted and no word from requester 1 is transmitted.
